// File: rtl/phase1_stage_sequencer.sv
// Phase-1 puzzle chain controller: enables one puzzle stage at a time, reacts
// to the active stage's clear/fail pulses, and tracks lives and the countdown
// timer. The phase ends in DONE (all stages cleared) or OVER (out of lives or
// time). Every (re)enable of a stage is preceded by at least one enable-low
// cycle, so each puzzle sees a rising enable edge and latches a new target.
module phase1_stage_sequencer #(
   parameter int NUM_PUZZLES  = 3,
   parameter int MAX_LIVES    = 3,
   parameter int TIME_LIMIT   = 90,
   parameter int TICK_DIV     = 50000000,
   parameter int PENALTY      = 10,
   parameter int FLASH_CYCLES = 25000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NUM_PUZZLES-1:0] puzzle_clear,
   input  logic [NUM_PUZZLES-1:0] puzzle_fail,
   output logic [NUM_PUZZLES-1:0] puzzle_en,
   output logic [2:0]             stage_idx,
   output logic [3:0]             lives_left,
   output logic [7:0]             time_left,
   output logic                   fail_flash,
   output logic                   phase_clear,
   output logic                   game_over
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int FW = $clog2(FLASH_CYCLES + 1);

   localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
   localparam logic [2:0]    LAST_STAGE = 3'(NUM_PUZZLES - 1);
   localparam logic [3:0]    LIVES_INIT = 4'(MAX_LIVES);
   localparam logic [7:0]    TIME_INIT  = 8'(TIME_LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      PLAY,
      FLASH,
      DONE,
      OVER
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [FW-1:0] flash_cnt;

   logic          sel_clear;
   logic          sel_fail;
   logic          tick;
   logic [7:0]    time_tick;
   logic [7:0]    time_pen;
   logic [3:0]    lives_dec;

   // Saturating subtraction of the fail penalty from the remaining time.
   function automatic logic [7:0] sat_sub_time(input logic [7:0] t, input int unsigned p);
      if (32'(t) <= p) begin
         return 8'd0;
      end
      return t - 8'(p);
   endfunction

   // One-hot enable pattern for a stage index.
   function automatic logic [NUM_PUZZLES-1:0] stage_onehot(input logic [2:0] idx);
      logic [NUM_PUZZLES-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_PUZZLES; i++) begin
         if (idx == 3'(i)) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Select the active stage's pulses and precompute timer/lives updates.
   // A tick that coincides with a fail is applied before the penalty.
   always_comb begin
      sel_clear = 1'b0;
      sel_fail  = 1'b0;
      for (int i = 0; i < NUM_PUZZLES; i++) begin
         if (stage_idx == 3'(i)) begin
            sel_clear = puzzle_clear[i];
            sel_fail  = puzzle_fail[i];
         end
      end
      tick      = (state == PLAY) && (presc == TICK_LAST);
      time_tick = tick ? (time_left - 8'd1) : time_left;
      time_pen  = sat_sub_time(time_tick, PENALTY);
      lives_dec = lives_left - 4'd1;
   end

   // Sequencer FSM with registered outputs, prescaler and flash counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         puzzle_en   <= '0;
         stage_idx   <= 3'd0;
         lives_left  <= LIVES_INIT;
         time_left   <= TIME_INIT;
         fail_flash  <= 1'b0;
         phase_clear <= 1'b0;
         game_over   <= 1'b0;
         presc       <= '0;
         flash_cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE, OVER: begin
               if (start) begin
                  stage_idx   <= 3'd0;
                  lives_left  <= LIVES_INIT;
                  time_left   <= TIME_INIT;
                  presc       <= '0;
                  phase_clear <= 1'b0;
                  game_over   <= 1'b0;
                  puzzle_en   <= '0;
                  state       <= ARM;
               end
            end

            ARM: begin
               puzzle_en <= stage_onehot(stage_idx);
               state     <= PLAY;
            end

            PLAY: begin
               presc     <= tick ? '0 : presc + 1'b1;
               time_left <= time_tick;
               if (sel_clear) begin
                  puzzle_en <= '0;
                  if (stage_idx == LAST_STAGE) begin
                     phase_clear <= 1'b1;
                     state       <= DONE;
                  end else begin
                     stage_idx <= stage_idx + 3'd1;
                     state     <= ARM;
                  end
               end else if (sel_fail) begin
                  puzzle_en  <= '0;
                  lives_left <= lives_dec;
                  time_left  <= time_pen;
                  if ((lives_dec == 4'd0) || (time_pen == 8'd0)) begin
                     game_over <= 1'b1;
                     state     <= OVER;
                  end else begin
                     fail_flash <= 1'b1;
                     flash_cnt  <= '0;
                     state      <= FLASH;
                  end
               end else if (tick && (time_tick == 8'd0)) begin
                  puzzle_en <= '0;
                  game_over <= 1'b1;
                  state     <= OVER;
               end
            end

            FLASH: begin
               if (flash_cnt == FLASH_LAST) begin
                  fail_flash <= 1'b0;
                  state      <= ARM;
               end else begin
                  flash_cnt <= flash_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
